vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator. All horizontal and vertical timings, sync polarities, counter width and pixel-clock divider are set by parameters.
- v_pos advances once per line; the previous block advanced it once per clock.
- Adds a run/stop control that always stops at a frame boundary, plus line-end and frame-end strobes.
- Sits between the system clock and the pixel/sprite renderers. It drives the VGA pins and the renderers' position inputs.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_counter.sv | 43 ++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared FSM states, default 640x480@60 timing and the sync-window helper
// used by the VGA timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_t;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    function automatic logic in_sync_window(input logic [31:0] pos,
                                            input logic [31:0] sync_start,
                                            input logic [31:0] sync_end);
        return (pos >= sync_start) && (pos <= sync_end);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with a registered sync level
// derived from the next position, so sync and position change together.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    input  logic [POS_W-1:0] max_pos,
    input  logic [POS_W-1:0] sync_start,
    input  logic [POS_W-1:0] sync_end,
    input  logic             sync_pol,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] pos_nxt,
    output logic             sync_lvl,
    output logic             wrap
);

    assign wrap = (pos == max_pos);

    always_comb begin
        pos_nxt = pos;
        if (clr)
            pos_nxt = '0;
        else if (adv)
            pos_nxt = wrap ? '0 : pos + POS_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= '0;
            sync_lvl <= ~sync_pol;
        end else begin
            pos      <= pos_nxt;
            sync_lvl <= in_sync_window(32'(pos_nxt), 32'(sync_start), 32'(sync_end))
                        ? sync_pol : ~sync_pol;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/position generator with frame-boundary run/stop.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = DEF_H_DISPLAY,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_DISPLAY  = DEF_V_DISPLAY,
    parameter int V_BOTTOM   = DEF_V_BOTTOM,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_TOP      = DEF_V_TOP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int POS_W      = 10
`ifdef VGA_FRAME_CNT_EN
    ,
    parameter int FRAME_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             h_sync,
    output logic             v_sync,
    output logic             display_on,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             pix_stb,
    output logic             line_end,
    output logic             frame_end,
    output logic             busy
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] frame_cnt
`endif
);

    localparam logic [POS_W-1:0] H_MAX  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [POS_W-1:0] H_SS   = POS_W'(H_DISPLAY + H_FRONT);
    localparam logic [POS_W-1:0] H_SE   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] H_DISP = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_MAX  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [POS_W-1:0] V_SS   = POS_W'(V_DISPLAY + V_BOTTOM);
    localparam logic [POS_W-1:0] V_SE   = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
    localparam logic [POS_W-1:0] V_DISP = POS_W'(V_DISPLAY);
    localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);

    vga_state_t       state, state_nxt;
    logic [3:0]       div, div_nxt;
    logic [POS_W-1:0] h_pos_nxt, v_pos_nxt;
    logic             h_wrap, v_wrap, clr;

    assign busy      = (state != IDLE);
    assign pix_stb   = busy && (div == DIV_LAST);
    assign line_end  = pix_stb && h_wrap;
    assign frame_end = line_end && v_wrap;
    assign clr       = (state == IDLE);

    vga_axis_counter #(.POS_W(POS_W)) u_h_axis (
        .clk(clk), .rst(rst), .adv(pix_stb), .clr(clr),
        .max_pos(H_MAX), .sync_start(H_SS), .sync_end(H_SE), .sync_pol(H_SYNC_POL),
        .pos(h_pos), .pos_nxt(h_pos_nxt), .sync_lvl(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(.POS_W(POS_W)) u_v_axis (
        .clk(clk), .rst(rst), .adv(line_end), .clr(clr),
        .max_pos(V_MAX), .sync_start(V_SS), .sync_end(V_SE), .sync_pol(V_SYNC_POL),
        .pos(v_pos), .pos_nxt(v_pos_nxt), .sync_lvl(v_sync), .wrap(v_wrap)
    );

    // A stop request only takes effect at a frame boundary; re-raising run
    // while draining simply resumes the frame in progress.
    always_comb begin
        state_nxt = state;
        div_nxt   = (clr || pix_stb) ? 4'd0 : div + 4'd1;
        case (state)
            IDLE:    if (run) state_nxt = RUN;
            RUN:     if (!run) state_nxt = frame_end ? IDLE : DRAIN;
            DRAIN:   if (run) state_nxt = RUN;
                     else if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div        <= 4'd0;
            display_on <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            display_on <= (h_pos_nxt < H_DISP) && (v_pos_nxt < V_DISP) && (state_nxt != IDLE);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_end)
            frame_cnt <= frame_cnt + FRAME_W'(1);
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, slow divided
// clock with inverted syncs, tiny timing) checked against an arithmetic model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst0, run0, hs0, vs0, de0, ps0, le0, fe0, bz0;
    logic [9:0] hp0, vp0;
    logic       rst1, run1, hs1, vs1, de1, ps1, le1, fe1, bz1;
    logic [5:0] hp1, vp1;
    logic       rst2, run2, hs2, vs2, de2, ps2, le2, fe2, bz2;
    logic [3:0] hp2, vp2;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
    logic [1:0]  fc2;
`endif

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst0), .run(run0), .h_sync(hs0), .v_sync(vs0),
        .display_on(de0), .h_pos(hp0), .v_pos(vp0), .pix_stb(ps0),
        .line_end(le0), .frame_end(fe0), .busy(bz0)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_DISPLAY(6), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(3), .POS_W(6)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .run(run1), .h_sync(hs1), .v_sync(vs1),
        .display_on(de1), .h_pos(hp1), .v_pos(vp1), .pix_stb(ps1),
        .line_end(le1), .frame_end(fe1), .busy(bz1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
        .CLK_DIV(1), .POS_W(4)
`ifdef VGA_FRAME_CNT_EN
        , .FRAME_W(2)
`endif
    ) u_dut2 (
        .clk(clk), .rst(rst2), .run(run2), .h_sync(hs2), .v_sync(vs2),
        .display_on(de2), .h_pos(hp2), .v_pos(vp2), .pix_stb(ps2),
        .line_end(le2), .frame_end(fe2), .busy(bz2)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected outputs after n clock edges of continuous running from (0,0).
    task automatic model_chk(input string tag, input int n, input int d, input int ht, input int vt,
                             input int hd, input int vd, input int hss, input int hse,
                             input int vss, input int vse, input logic hpol, input logic vpol,
                             input logic [31:0] h_o, input logic [31:0] v_o,
                             input logic hs_o, input logic vs_o, input logic de_o,
                             input logic ps_o, input logic le_o, input logic fe_o, input logic bz_o);
        int   p, eh, ev;
        logic eps, ele, efe;
        p   = n / d;
        eh  = p % ht;
        ev  = (p / ht) % vt;
        eps = ((n % d) == d - 1);
        ele = eps && (eh == ht - 1);
        efe = ele && (ev == vt - 1);
        chk ({tag, ".h_pos"},      h_o, eh);
        chk ({tag, ".v_pos"},      v_o, ev);
        chk1({tag, ".h_sync"},     hs_o, (eh >= hss && eh <= hse) ? hpol : !hpol);
        chk1({tag, ".v_sync"},     vs_o, (ev >= vss && ev <= vse) ? vpol : !vpol);
        chk1({tag, ".display_on"}, de_o, (eh < hd) && (ev < vd));
        chk1({tag, ".pix_stb"},    ps_o, eps);
        chk1({tag, ".line_end"},   le_o, ele);
        chk1({tag, ".frame_end"},  fe_o, efe);
        chk1({tag, ".busy"},       bz_o, 1'b1);
    endtask

    task automatic m0(input int n);
        model_chk("d0", n, 1, 800, 525, 640, 480, 656, 751, 490, 491, 1'b0, 1'b0,
                  32'(hp0), 32'(vp0), hs0, vs0, de0, ps0, le0, fe0, bz0);
    endtask

    task automatic m1(input int n);
        model_chk("d1", n, 3, 24, 10, 16, 6, 18, 21, 7, 8, 1'b1, 1'b1,
                  32'(hp1), 32'(vp1), hs1, vs1, de1, ps1, le1, fe1, bz1);
    endtask

    task automatic m2(input int n);
        model_chk("d2", n, 1, 8, 6, 4, 3, 5, 6, 4, 4, 1'b0, 1'b0,
                  32'(hp2), 32'(vp2), hs2, vs2, de2, ps2, le2, fe2, bz2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int e0, e1, e2, n, k, tgt, blip;
    int hs_low, hs_first, de_cnt, last_le, le_per, last_fe, fe_per;
    int ps_cnt, h5_cnt, hs_hi, vs_hi, fe_h, fe_v;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        run0 = 1'b1; run1 = 1'b0; run2 = 1'b0;
        repeat (3) tick();

        // Reset state, with run already high on dut0
        chk ("rst.h_pos", 32'(hp0), 0);
        chk ("rst.v_pos", 32'(vp0), 0);
        chk1("rst.h_sync", hs0, 1'b1);
        chk1("rst.v_sync", vs0, 1'b1);
        chk1("rst.display_on", de0, 1'b0);
        chk1("rst.busy", bz0, 1'b0);
        chk1("rst.pix_stb", ps0, 1'b0);
        chk1("rst.frame_end", fe0, 1'b0);
        chk1("rst.pol_h_sync", hs1, 1'b0);
        chk1("rst.pol_v_sync", vs1, 1'b0);

        // Release: RUN on the first edge after release
        rst0 = 1'b0;
        tick();
        e0 = cyc;
        chk1("entry.busy", bz0, 1'b1);
        chk ("entry.h_pos", 32'(hp0), 0);
        chk1("entry.display_on", de0, 1'b1);

        // Default timing, three full lines
        hs_low = 0; hs_first = -1; de_cnt = 0; last_le = -1; le_per = -1;
        for (int i = 0; i < 2400; i++) begin
            n = cyc - e0;
            if ($urandom_range(0, 15) == 0) m0(n);
            if (vp0 == 10'd0) begin
                if (!hs0) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(hp0);
                end
                if (de0) de_cnt++;
            end
            if (le0) begin
                if (last_le >= 0) le_per = cyc - last_le;
                last_le = cyc;
            end
            tick();
        end
        chk("d0.h_sync_low_clks", hs_low, 96);
        chk("d0.h_sync_first_pos", hs_first, 656);
        chk("d0.display_clks_line0", de_cnt, 640);
        chk("d0.line_period", le_per, 800);
        chk("d0.after3lines.v_pos", 32'(vp0), 3);
        chk("d0.after3lines.h_pos", 32'(hp0), 0);

        // Abort mid-frame: reset acts without a clock edge
        k = 0;
        while (!(hp0 == 10'd300 && vp0 == 10'd3) && k < 1000) begin
            tick();
            k++;
        end
        chk1("abort.reached", (hp0 == 10'd300 && vp0 == 10'd3), 1'b1);
        m0(cyc - e0);
        #2;
        rst0 = 1'b1;
        run0 = 1'b0;
        #1;
        chk ("abort.h_pos", 32'(hp0), 0);
        chk ("abort.v_pos", 32'(vp0), 0);
        chk1("abort.h_sync", hs0, 1'b1);
        chk1("abort.v_sync", vs0, 1'b1);
        chk1("abort.display_on", de0, 1'b0);
        chk1("abort.busy", bz0, 1'b0);
        chk1("abort.pix_stb", ps0, 1'b0);
        chk1("abort.line_end", le0, 1'b0);
        tick();

        // Divided clock, active-high syncs, two frames
        rst1 = 1'b0;
        run1 = 1'b1;
        tick();
        e1 = cyc;
        ps_cnt = 0; h5_cnt = 0; hs_hi = 0; vs_hi = 0;
        last_le = -1; le_per = -1; last_fe = -1; fe_per = -1;
        for (int i = 0; i < 1440; i++) begin
            n = cyc - e1;
            if ($urandom_range(0, 7) == 0) m1(n);
            if (n < 720) begin
                if (hs1) hs_hi++;
                if (vs1) vs_hi++;
                if (hp1 == 6'd5 && vp1 == 6'd0) h5_cnt++;
            end
            if (ps1) ps_cnt++;
            if (le1) begin
                if (last_le >= 0) le_per = cyc - last_le;
                last_le = cyc;
            end
            if (fe1) begin
                if (last_fe >= 0) fe_per = cyc - last_fe;
                last_fe = cyc;
            end
            tick();
        end
        chk("d1.pix_stb_count", ps_cnt, 480);
        chk("d1.line_period", le_per, 72);
        chk("d1.frame_period", fe_per, 720);
        chk("d1.h_pos_hold", h5_cnt, 3);
        chk("d1.h_sync_high_clks", hs_hi, 120);
        chk("d1.v_sync_high_clks", vs_hi, 144);
        run1 = 1'b0;

        // Tiny timing: five frames with a short run drop inside frame 1
        rst2 = 1'b0;
        run2 = 1'b1;
        tick();
        e2 = cyc;
        blip = int'($urandom_range(50, 90));
        last_fe = -1; fe_per = -1;
        for (int i = 0; i < 240; i++) begin
            n = cyc - e2;
            m2(n);
`ifdef VGA_FRAME_CNT_EN
            if (n % 48 == 0) chk("d2.frame_cnt", 32'(fc2), (n / 48) % 4);
`endif
            if (fe2) begin
                if (last_fe >= 0) fe_per = cyc - last_fe;
                last_fe = cyc;
            end
            if (n == blip) run2 = 1'b0;
            if (n == blip + 3) run2 = 1'b1;
            tick();
        end
        chk("d2.frame_period", fe_per, 48);

        // Graceful stop requested on line 2
        tgt = int'($urandom_range(0, 7));
        k = 0;
        while (!(vp2 == 4'd2 && int'(hp2) == tgt) && k < 100) begin
            tick();
            k++;
        end
        chk1("stop.reached", (vp2 == 4'd2 && int'(hp2) == tgt), 1'b1);
        run2 = 1'b0;
        fe_h = -1; fe_v = -1; k = 0;
        while (bz2 && k < 100) begin
            if (fe2) begin
                fe_h = int'(hp2);
                fe_v = int'(vp2);
            end
            tick();
            k++;
        end
        chk ("stop.idle_edge", cyc - e2, 288);
        chk ("stop.fe_h", fe_h, 7);
        chk ("stop.fe_v", fe_v, 5);
        chk1("stop.busy", bz2, 1'b0);
        chk ("stop.h_pos", 32'(hp2), 0);
        chk ("stop.v_pos", 32'(vp2), 0);
        chk1("stop.display_on", de2, 1'b0);
        chk1("stop.pix_stb", ps2, 1'b0);
        repeat ($urandom_range(2, 10)) tick();
        chk ("idle.h_pos", 32'(hp2), 0);
        chk ("idle.v_pos", 32'(vp2), 0);
        chk1("idle.busy", bz2, 1'b0);

        // Restart from (0,0)
        run2 = 1'b1;
        tick();
        e2 = cyc;
        chk ("restart.h_pos", 32'(hp2), 0);
        chk ("restart.v_pos", 32'(vp2), 0);
        chk1("restart.busy", bz2, 1'b1);
        chk1("restart.display_on", de2, 1'b1);
`ifdef VGA_FRAME_CNT_EN
        chk("restart.frame_cnt", 32'(fc2), 2);
`endif
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) m2(cyc - e2);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
